// File: rtl/cnn_pkg.sv
// Shared constants, tap numbering and FSM state type for the 3x3 window generator.
package cnn_pkg;

  localparam int unsigned WIDTH   = 9;
  localparam int unsigned Y_WIDTH = 2 * WIDTH;

  localparam int unsigned TAP_NW = 1;
  localparam int unsigned TAP_N  = 2;
  localparam int unsigned TAP_NE = 3;
  localparam int unsigned TAP_W  = 4;
  localparam int unsigned TAP_C  = 5;
  localparam int unsigned TAP_E  = 6;
  localparam int unsigned TAP_SW = 7;
  localparam int unsigned TAP_S  = 8;
  localparam int unsigned TAP_SE = 9;

  typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

  // Bit t-1 set means tap t lies inside the image and is passed through.
  function automatic logic [8:0] tap_keep(input logic top, input logic bottom,
                                          input logic left, input logic right);
    logic [8:0] keep;
    keep = '1;
    if (top) begin
      keep[TAP_NW-1] = 1'b0;
      keep[TAP_N-1]  = 1'b0;
      keep[TAP_NE-1] = 1'b0;
    end
    if (bottom) begin
      keep[TAP_SW-1] = 1'b0;
      keep[TAP_S-1]  = 1'b0;
      keep[TAP_SE-1] = 1'b0;
    end
    if (left) begin
      keep[TAP_NW-1] = 1'b0;
      keep[TAP_W-1]  = 1'b0;
      keep[TAP_SW-1] = 1'b0;
    end
    if (right) begin
      keep[TAP_NE-1] = 1'b0;
      keep[TAP_E-1]  = 1'b0;
      keep[TAP_SE-1] = 1'b0;
    end
    return keep;
  endfunction

endpackage

// File: rtl/cnn_window_gen_if.sv
// Pixel-in / window-out streaming bus of the 3x3 window generator.
interface cnn_window_gen_if #(
  parameter int unsigned WIDTH = cnn_pkg::WIDTH,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
);

  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     in_u;
  logic signed [2*WIDTH-1:0]   in_y;
  logic                        out_valid;
  logic                        out_ready;
  logic [9*WIDTH-1:0]          out_u;
  logic [18*WIDTH-1:0]         out_y;
  logic [$clog2(IMG_H)-1:0]    out_row;
  logic [$clog2(IMG_W)-1:0]    out_col;
  logic                        out_last;

  modport slave (
    input  in_valid, in_u, in_y, out_ready,
    output in_ready, out_valid, out_u, out_y, out_row, out_col, out_last
  );

  modport master (
    output in_valid, in_u, in_y, out_ready,
    input  in_ready, out_valid, out_u, out_y, out_row, out_col, out_last
  );

endinterface

// File: rtl/cnn_line_buffer.sv
// Circular delay line: data_o is the word written Depth shifts ago.
module cnn_line_buffer #(
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 27
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 shift_en_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AW-1:0]        ptr_q;

  assign data_o = mem_q[ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (shift_en_i) begin
      ptr_q <= (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
    end
  end

  // Storage is deliberately not reset; boundary masking hides stale words.
  always_ff @(posedge clk_i) begin
    if (shift_en_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Streaming 3x3 {Y,U} neighbourhood generator with zero padding at the image border.
module cnn_window_gen #(
  parameter int unsigned WIDTH = cnn_pkg::WIDTH,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input logic             clk,
  input logic             rst,
  cnn_window_gen_if.slave win_if
);
  import cnn_pkg::*;

  localparam int unsigned PW       = 3 * WIDTH;
  localparam int unsigned YW       = 2 * WIDTH;
  localparam int unsigned NumPix   = IMG_H * IMG_W;
  localparam int unsigned NumSlots = NumPix + IMG_W + 1;
  localparam int unsigned SW       = $clog2(NumSlots);
  localparam int unsigned RW       = $clog2(IMG_H);
  localparam int unsigned CW       = $clog2(IMG_W);

  localparam logic [SW-1:0] LastFill = SW'(IMG_W);
  localparam logic [SW-1:0] LastPix  = SW'(NumPix - 1);
  localparam logic [SW-1:0] LastSlot = SW'(NumSlots - 1);
  localparam logic [RW-1:0] LastRow  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] LastCol  = CW'(IMG_W - 1);

  state_e              state_q;
  logic [SW-1:0]       slot_q;
  logic [RW-1:0]       row_q;
  logic [CW-1:0]       col_q;
  logic [PW-1:0]       win_q [9];
  logic [PW-1:0]       win_d [9];
  logic [PW-1:0]       slot_pix, lb0_out, lb1_out;
  logic                can_adv, adv, emit;
  logic [8:0]          keep;
  logic [9*WIDTH-1:0]  u_d;
  logic [18*WIDTH-1:0] y_d;

  logic                out_valid_q, out_last_q;
  logic [9*WIDTH-1:0]  out_u_q;
  logic [18*WIDTH-1:0] out_y_q;
  logic [RW-1:0]       out_row_q;
  logic [CW-1:0]       out_col_q;

  assign can_adv         = !out_valid_q || win_if.out_ready;
  assign win_if.in_ready = can_adv && (state_q != StFlush);
  assign adv             = can_adv && ((state_q == StFlush) || win_if.in_valid);
  assign emit            = adv && (state_q != StFill);
  assign slot_pix        = (state_q == StFlush) ? '0 : {win_if.in_y, win_if.in_u};

  cnn_line_buffer #(.Depth(IMG_W), .DataWidth(PW)) u_lb0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .shift_en_i (adv),
    .data_i     (slot_pix),
    .data_o     (lb0_out)
  );

  cnn_line_buffer #(.Depth(IMG_W), .DataWidth(PW)) u_lb1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .shift_en_i (adv),
    .data_i     (lb0_out),
    .data_o     (lb1_out)
  );

  // Right column takes pixels s-2W, s-W, s; the centre is then pixel s-W-1.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]     = win_q[3*r+1];
      win_d[3*r + 1] = win_q[3*r+2];
    end
    win_d[2] = lb1_out;
    win_d[5] = lb0_out;
    win_d[8] = slot_pix;
  end

  assign keep = tap_keep(row_q == '0, row_q == LastRow, col_q == '0, col_q == LastCol);

  always_comb begin
    u_d = '0;
    y_d = '0;
    for (int t = 0; t < 9; t++) begin
      if (keep[t]) begin
        u_d[t*WIDTH +: WIDTH] = win_d[t][WIDTH-1:0];
        y_d[t*YW +: YW]       = win_d[t][PW-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      slot_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_u_q     <= '0;
      out_y_q     <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      for (int t = 0; t < 9; t++) win_q[t] <= '0;
    end else begin
      if (adv) begin
        for (int t = 0; t < 9; t++) win_q[t] <= win_d[t];
        slot_q <= slot_q + 1'b1;
        unique case (state_q)
          StFill:  if (slot_q == LastFill) state_q <= StRun;
          StRun:   if (slot_q == LastPix) state_q <= StFlush;
          StFlush: begin
            // The final window sits in the output register; the next frame may start.
            if (slot_q == LastSlot) begin
              state_q <= StFill;
              slot_q  <= '0;
            end
          end
          default: state_q <= StFill;
        endcase
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_u_q     <= u_d;
        out_y_q     <= y_d;
        out_row_q   <= row_q;
        out_col_q   <= col_q;
        out_last_q  <= (row_q == LastRow) && (col_q == LastCol);
        if (col_q == LastCol) begin
          col_q <= '0;
          row_q <= (row_q == LastRow) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else if (win_if.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign win_if.out_valid = out_valid_q;
  assign win_if.out_last  = out_last_q;
  assign win_if.out_u     = out_u_q;
  assign win_if.out_y     = out_y_q;
  assign win_if.out_row   = out_row_q;
  assign win_if.out_col   = out_col_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen on a 4x4 image with hand-computed window vectors.
module tb_cnn_window_gen;
  import cnn_pkg::*;

  localparam int W    = 9;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;

  typedef struct packed {
    logic [9*W-1:0]  u;
    logic [18*W-1:0] y;
    logic [1:0]      row;
    logic [1:0]      col;
    logic            last;
  } win_t;

  typedef struct packed {
    logic [3:0]      idx;
    logic [9*W-1:0]  u;
    logic [18*W-1:0] y;
    logic            last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_window_gen_if #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) bus ();

  cnn_window_gen #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk    (clk),
    .rst    (rst),
    .win_if (bus)
  );

  int   nvec = 0;
  int   nerr = 0;
  int   pat [2];
  int   pix_cnt, cyc, first_ov, fire6, stall_n, ready_lo, nlast;
  win_t snap;
  win_t cap [$];
  vec_t vecs [6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pattern 0: U=n, Y=100+n. Pattern 1: same but pixel (2,2) carries the most negative values.
  function automatic int pix_u(input int p, input int r, input int c);
    if (r < 0 || r >= IH || c < 0 || c >= IW) return 0;
    if (p == 1 && r == 2 && c == 2) return -256;
    return r * IW + c;
  endfunction

  function automatic int pix_y(input int p, input int r, input int c);
    if (r < 0 || r >= IH || c < 0 || c >= IW) return 0;
    if (p == 1 && r == 2 && c == 2) return -131072;
    return 100 + r * IW + c;
  endfunction

  function automatic win_t model(input int p, input int n);
    win_t m;
    int   r, c;
    r      = n / IW;
    c      = n % IW;
    m.row  = 2'(r);
    m.col  = 2'(c);
    m.last = (n == NPIX - 1);
    for (int t = 0; t < 9; t++) begin
      m.u[t*W +: W]     = W'(pix_u(p, r + t / 3 - 1, c + t % 3 - 1));
      m.y[t*2*W +: 2*W] = (2*W)'(pix_y(p, r + t / 3 - 1, c + t % 3 - 1));
    end
    return m;
  endfunction

  function automatic logic [9*W-1:0] pk_u(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    return {W'(a8), W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic logic [18*W-1:0] pk_y(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
    return {(2*W)'(a8), (2*W)'(a7), (2*W)'(a6), (2*W)'(a5), (2*W)'(a4),
            (2*W)'(a3), (2*W)'(a2), (2*W)'(a1), (2*W)'(a0)};
  endfunction

  function automatic win_t cur_win();
    win_t w;
    w.u    = bus.out_u;
    w.y    = bus.out_y;
    w.row  = bus.out_row;
    w.col  = bus.out_col;
    w.last = bus.out_last;
    return w;
  endfunction

  task automatic drive(input int nfr);
    int f, n;
    f            = pix_cnt / NPIX;
    n            = pix_cnt % NPIX;
    if (f > 1) f = 1;
    bus.in_valid = (pix_cnt < nfr * NPIX);
    bus.in_u     = W'(pix_u(pat[f], n / IW, n % IW));
    bus.in_y     = (2*W)'(pix_y(pat[f], n / IW, n % IW));
  endtask

  task automatic run_frames(input int nfr, input int stall_after);
    int guard;
    guard = 0;
    cap.delete();
    pix_cnt  = 0;
    stall_n  = 0;
    first_ov = -1;
    fire6    = -1;
    ready_lo = 0;
    cyc      = 0;
    while (cap.size() < nfr * NPIX && guard < 400) begin
      logic stalled;
      drive(nfr);
      stalled       = (stall_after >= 0) && (cap.size() == stall_after) && (stall_n < 5);
      bus.out_ready = !stalled;
      #1;
      if (stalled) begin
        chk($sformatf("stall%0d_valid", stall_n), 256'(bus.out_valid), 256'(1));
        chk($sformatf("stall%0d_in_ready", stall_n), 256'(bus.in_ready), 256'(0));
        if (stall_n == 0) snap = cur_win();
        else chk($sformatf("stall%0d_hold", stall_n), 256'(cur_win()), 256'(snap));
        stall_n++;
      end
      if (bus.in_valid && !bus.in_ready) ready_lo++;
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.in_valid && bus.in_ready) begin
        pix_cnt++;
        if (pix_cnt == 6) fire6 = cyc;
      end
      if (bus.out_valid && bus.out_ready) cap.push_back(cur_win());
      @(posedge clk);
      #1;
      cyc++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("run_complete", 256'(cap.size()), 256'(nfr * NPIX));
    nlast = 0;
    foreach (cap[k]) if (cap[k].last) nlast++;
  endtask

  task automatic check_frames(input string tag);
    foreach (cap[k])
      chk($sformatf("%s_win%0d", tag, k), 256'(cap[k]), 256'(model(pat[k / NPIX], k % NPIX)));
  endtask

  task automatic check_table(input string tag);
    foreach (vecs[i]) begin
      win_t w;
      w = (cap.size() > vecs[i].idx) ? cap[vecs[i].idx] : '0;
      chk($sformatf("%s_vec%0d_u", tag, vecs[i].idx), 256'(w.u), 256'(vecs[i].u));
      chk($sformatf("%s_vec%0d_y", tag, vecs[i].idx), 256'(w.y), 256'(vecs[i].y));
      chk($sformatf("%s_vec%0d_last", tag, vecs[i].idx), 256'(w.last), 256'(vecs[i].last));
    end
  endtask

  initial begin
    int guard;
    vecs[0] = '{idx: 4'd0,  u: pk_u(0, 0, 0, 0, 0, 1, 0, 4, 5),
                y: pk_y(0, 0, 0, 0, 100, 101, 0, 104, 105), last: 1'b0};
    vecs[1] = '{idx: 4'd5,  u: pk_u(0, 1, 2, 4, 5, 6, 8, 9, 10),
                y: pk_y(100, 101, 102, 104, 105, 106, 108, 109, 110), last: 1'b0};
    vecs[2] = '{idx: 4'd15, u: pk_u(10, 11, 0, 14, 15, 0, 0, 0, 0),
                y: pk_y(110, 111, 0, 114, 115, 0, 0, 0, 0), last: 1'b1};
    vecs[3] = '{idx: 4'd3,  u: pk_u(0, 0, 0, 2, 3, 0, 6, 7, 0),
                y: pk_y(0, 0, 0, 102, 103, 0, 106, 107, 0), last: 1'b0};
    vecs[4] = '{idx: 4'd12, u: pk_u(0, 8, 9, 0, 12, 13, 0, 0, 0),
                y: pk_y(0, 108, 109, 0, 112, 113, 0, 0, 0), last: 1'b0};
    vecs[5] = '{idx: 4'd9,  u: pk_u(4, 5, 6, 8, 9, 10, 12, 13, 14),
                y: pk_y(104, 105, 106, 108, 109, 110, 112, 113, 114), last: 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_u      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_last", 256'(bus.out_last), 256'(0));
    chk("rst_out_u", 256'(bus.out_u), 256'(0));
    chk("rst_out_y", 256'(bus.out_y), 256'(0));
    chk("rst_out_row", 256'(bus.out_row), 256'(0));
    chk("rst_out_col", 256'(bus.out_col), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));

    // Single frame, no backpressure.
    pat[0] = 0;
    pat[1] = 0;
    run_frames(1, -1);
    check_table("s1");
    check_frames("s1");
    chk("s1_first_latency", 256'(first_ov), 256'(fire6 + 1));
    chk("s1_last_count", 256'(nlast), 256'(1));

    // Backpressure after the third window, with extreme negative values at (2,2).
    pat[0] = 1;
    run_frames(1, 3);
    check_frames("s2");
    chk("s2_stall_cycles", 256'(stall_n), 256'(5));
    chk("s2_c22_u5", 256'(cap[10].u[(TAP_C-1)*W +: W]), 256'(9'h100));
    chk("s2_c22_y5", 256'(cap[10].y[(TAP_C-1)*2*W +: 2*W]), 256'(18'h20000));
    chk("s2_c21_u6", 256'(cap[9].u[(TAP_E-1)*W +: W]), 256'(9'h100));
    chk("s2_c33_y1", 256'(cap[15].y[(TAP_NW-1)*2*W +: 2*W]), 256'(18'h20000));

    // Reset after 7 accepted pixels, then a clean frame.
    pat[0]        = 0;
    pix_cnt       = 0;
    guard         = 0;
    bus.out_ready = 1'b1;
    while (pix_cnt < 7 && guard < 50) begin
      drive(1);
      #1;
      if (bus.in_valid && bus.in_ready) pix_cnt++;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("s3_partial_accepts", 256'(pix_cnt), 256'(7));
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("s3_rst_out_valid", 256'(bus.out_valid), 256'(0));
    run_frames(1, -1);
    check_table("s3");
    check_frames("s3");

    // Two back-to-back frames with in_valid held high.
    pat[0] = 0;
    pat[1] = 1;
    run_frames(2, -1);
    check_frames("s4");
    chk("s4_flush_ready_low", 256'(ready_lo), 256'(5));
    chk("s4_last_count", 256'(nlast), 256'(2));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
